etapa_mem_lsu: RTL and testbench

Load/store unit for the MEM stage of the five-stage RISC-V pipeline. It turns the EX/MEM control, address and store data into a request/ready transaction on the data-memory port. It generates byte enables and aligned store data, and sign- or zero-extends load data. It drives `rd_o` straight into the `rd_i` input of the MEM/WB register, and holds the front of the pipeline with `stall_o` until the access completes.

---
 rtl/lsu_pkg.sv | 38 +++
 rtl/etapa_mem_lsu_alineador_carga.sv | 39 +++
 rtl/etapa_mem_lsu.sv | 144 ++++++++++++++
 tb/tb_etapa_mem_lsu.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types and constants for the MEM-stage load/store unit.
// Holds the FSM state encoding, the RISC-V funct3 access codes and the byte-enable patterns.
// No logic besides a small funct3 legality helper.
package lsu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } lsu_state_t;

  // Load encodings
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  // Store encodings
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  localparam logic [3:0] BE_NONE = 4'b0000;
  localparam logic [3:0] BE_B0   = 4'b0001;
  localparam logic [3:0] BE_LO   = 4'b0011;
  localparam logic [3:0] BE_HI   = 4'b1100;
  localparam logic [3:0] BE_ALL  = 4'b1111;

  // funct3 is meaningful only for the direction it is used with
  function automatic logic f3_legal(input logic is_load, input logic [2:0] f3);
    if (is_load) begin
      return (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
             (f3 == F3_LBU) || (f3 == F3_LHU);
    end
    return (f3 == F3_SB) || (f3 == F3_SH) || (f3 == F3_SW);
  endfunction

endpackage

// File: rtl/etapa_mem_lsu_alineador_carga.sv
// Load extractor: picks the byte/halfword named by the address offset and extends it.
// Purely combinational, zero latency.
// No flow control; the caller decides when the result is valid.
module alineador_carga
  import lsu_pkg::*;
(
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_off,
  input  logic [31:0] i_rdata,
  output logic [31:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Lane selection from the word offset
  always_comb begin
    w_half = i_off[1] ? i_rdata[31:16] : i_rdata[15:0];
    case (i_off)
      2'd0:    w_byte = i_rdata[7:0];
      2'd1:    w_byte = i_rdata[15:8];
      2'd2:    w_byte = i_rdata[23:16];
      default: w_byte = i_rdata[31:24];
    endcase
  end

  // Sign or zero extension according to the access type
  always_comb begin
    case (i_funct3)
      F3_LB:   o_data = {{24{w_byte[7]}}, w_byte};
      F3_LH:   o_data = {{16{w_half[15]}}, w_half};
      F3_LW:   o_data = i_rdata;
      F3_LBU:  o_data = {24'd0, w_byte};
      F3_LHU:  o_data = {16'd0, w_half};
      default: o_data = 32'd0;
    endcase
  end

endmodule

// File: rtl/etapa_mem_lsu.sv
// MEM-stage load/store unit: issues one request/ready data-memory access per memory instruction.
// Latency: 3 cycles minimum (IDLE, WAIT, DONE), plus one cycle per WAIT cycle without ready.
// Backpressure: stall_o holds the pipeline front until DONE; an unanswered request aborts after TIMEOUT cycles.
module etapa_mem_lsu
  import lsu_pkg::*;
#(
  parameter int TIMEOUT = 64
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        memreadm_i,
  input  logic        memwritem_i,
  input  logic [2:0]  funct3m_i,
  input  logic [31:0] aluresultm_i,
  input  logic [31:0] writedatam_i,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [31:0] dmem_addr_o,
  output logic [3:0]  dmem_be_o,
  output logic [31:0] dmem_wdata_o,
  input  logic        dmem_ready_i,
  input  logic [31:0] dmem_rdata_i,
  output logic [31:0] rd_o,
  output logic        stall_o,
  output logic        fault_o
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  lsu_state_t  r_state;
  logic [CW-1:0] r_cnt;
  logic [29:0] r_waddr;
  logic        r_we;
  logic [3:0]  r_be;
  logic [31:0] r_wdata;
  logic [2:0]  r_f3;
  logic [1:0]  r_off;
  logic [31:0] r_rd;

  logic        w_access;
  logic        w_align_ok;
  logic        w_legal;
  logic [3:0]  w_st_be;
  logic [31:0] w_st_wdata;
  logic [31:0] w_ld_data;
  logic        w_in_wait;
  logic        w_timeout;

  assign w_access = memreadm_i | memwritem_i;

  // Alignment: halfwords on even addresses, words on multiples of four
  always_comb begin
    case (funct3m_i[1:0])
      2'b01:   w_align_ok = ~aluresultm_i[0];
      2'b10:   w_align_ok = (aluresultm_i[1:0] == 2'b00);
      default: w_align_ok = 1'b1;
    endcase
  end

  assign w_legal = (memreadm_i ^ memwritem_i) && f3_legal(memreadm_i, funct3m_i) && w_align_ok;

  // Store lane generator: replicate the datum so every enabled lane carries it
  always_comb begin
    w_st_be    = BE_ALL;
    w_st_wdata = writedatam_i;
    case (funct3m_i[1:0])
      2'b00: begin
        w_st_be    = BE_B0 << aluresultm_i[1:0];
        w_st_wdata = {4{writedatam_i[7:0]}};
      end
      2'b01: begin
        w_st_be    = aluresultm_i[1] ? BE_HI : BE_LO;
        w_st_wdata = {2{writedatam_i[15:0]}};
      end
      default: ;
    endcase
  end

  alineador_carga u_alineador (
    .i_funct3 (r_f3),
    .i_off    (r_off),
    .i_rdata  (dmem_rdata_i),
    .o_data   (w_ld_data)
  );

  assign w_in_wait = (r_state == ST_WAIT);
  assign w_timeout = w_in_wait && !dmem_ready_i && (r_cnt == CNT_LAST);

  // Access FSM: latch the request in IDLE, hold it through WAIT, present the result in DONE
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_waddr <= '0;
      r_we    <= 1'b0;
      r_be    <= BE_NONE;
      r_wdata <= '0;
      r_f3    <= '0;
      r_off   <= '0;
      r_rd    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_access && w_legal) begin
            r_waddr <= aluresultm_i[31:2];
            r_we    <= memwritem_i;
            r_be    <= memwritem_i ? w_st_be : BE_ALL;
            r_wdata <= memwritem_i ? w_st_wdata : 32'd0;
            r_f3    <= funct3m_i;
            r_off   <= aluresultm_i[1:0];
            r_cnt   <= '0;
            r_state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (dmem_ready_i) begin
            r_rd    <= r_we ? 32'd0 : w_ld_data;
            r_state <= ST_DONE;
          end else if (r_cnt == CNT_LAST) begin
            r_rd    <= 32'd0;
            r_state <= ST_DONE;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Memory port is live only in WAIT, so reset drops it without waiting for an edge
  assign dmem_req_o   = w_in_wait;
  assign dmem_we_o    = w_in_wait & r_we;
  assign dmem_addr_o  = w_in_wait ? {r_waddr, 2'b00} : 32'd0;
  assign dmem_be_o    = w_in_wait ? r_be : BE_NONE;
  assign dmem_wdata_o = w_in_wait ? r_wdata : 32'd0;

  assign rd_o    = (r_state == ST_DONE) ? r_rd : 32'd0;
  assign stall_o = w_in_wait || ((r_state == ST_IDLE) && w_access && w_legal);
  assign fault_o = ((r_state == ST_IDLE) && w_access && !w_legal) || w_timeout;

endmodule

// File: tb/tb_etapa_mem_lsu.sv
module tb_etapa_mem_lsu;

  localparam int TO = 8;

  logic        clk_i = 1'b0;
  logic        reset_i = 1'b0;
  logic        memreadm_i = 1'b0;
  logic        memwritem_i = 1'b0;
  logic [2:0]  funct3m_i = 3'd0;
  logic [31:0] aluresultm_i = 32'd0;
  logic [31:0] writedatam_i = 32'd0;
  logic        dmem_req_o;
  logic        dmem_we_o;
  logic [31:0] dmem_addr_o;
  logic [3:0]  dmem_be_o;
  logic [31:0] dmem_wdata_o;
  logic        dmem_ready_i = 1'b0;
  logic [31:0] dmem_rdata_i = 32'd0;
  logic [31:0] rd_o;
  logic        stall_o;
  logic        fault_o;

  int checks = 0;
  int errors = 0;

  etapa_mem_lsu #(.TIMEOUT(TO)) dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .memreadm_i(memreadm_i), .memwritem_i(memwritem_i),
    .funct3m_i(funct3m_i), .aluresultm_i(aluresultm_i), .writedatam_i(writedatam_i),
    .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o),
    .dmem_be_o(dmem_be_o), .dmem_wdata_o(dmem_wdata_o),
    .dmem_ready_i(dmem_ready_i), .dmem_rdata_i(dmem_rdata_i),
    .rd_o(rd_o), .stall_o(stall_o), .fault_o(fault_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          delay;     // WAIT cycles before ready; -1 = never
    logic [31:0] e_addr;
    logic [3:0]  e_be;      // checked for stores only
    logic [31:0] e_wdata;   // checked for stores only
    logic [31:0] e_rd;
    int          e_stalls;
    logic        e_fault;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // Reference for store lanes, written with plain arithmetic
  function automatic void model_store(input logic [2:0] f3, input logic [31:0] addr,
                                      input logic [31:0] d, output logic [3:0] be,
                                      output logic [31:0] wd);
    int unsigned off;
    off = addr % 4;
    if (f3 == 3'd0) begin
      be = 4'(1 << off);
      wd = (d & 32'hFF) * 32'h01010101;
    end else if (f3 == 3'd1) begin
      be = (off == 2) ? 4'hC : 4'h3;
      wd = (d & 32'hFFFF) * 32'h00010001;
    end else begin
      be = 4'hF;
      wd = d;
    end
  endfunction

  // Reference for load extraction: shift, mask, and subtract to sign-extend
  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] addr,
                                             input logic [31:0] w);
    int unsigned sh;
    longint v;
    sh = (addr % 4) * 8;
    case (f3)
      3'd0: begin v = (w >> sh) & 32'hFF;   if (v >= 128)   v = v - 256;   end
      3'd1: begin v = (w >> sh) & 32'hFFFF; if (v >= 32768) v = v - 65536; end
      3'd4: v = (w >> sh) & 32'hFF;
      3'd5: v = (w >> sh) & 32'hFFFF;
      default: v = w;
    endcase
    return v[31:0];
  endfunction

  task automatic run_txn(input vec_t v, input string nm);
    int stalls, waits;
    logic done, fault_seen;
    @(negedge clk_i);
    memreadm_i = v.rd; memwritem_i = v.wr; funct3m_i = v.f3;
    aluresultm_i = v.addr; writedatam_i = v.wdata; dmem_rdata_i = v.rdata;
    dmem_ready_i = 1'b0;
    #1;
    chk({nm, "_idle_stall"}, stall_o, 1'b1);
    chk({nm, "_idle_fault"}, fault_o, 1'b0);
    stalls = 1; waits = 0; done = 1'b0; fault_seen = 1'b0;
    @(negedge clk_i);
    memreadm_i = 1'b0; memwritem_i = 1'b0;
    for (int c = 0; c < 4 * TO && !done; c++) begin
      if (dmem_req_o) begin
        dmem_ready_i = (v.delay >= 0) && (waits == v.delay);
        #1;
        chk({nm, "_addr"}, dmem_addr_o, v.e_addr);
        chk({nm, "_we"}, dmem_we_o, v.wr);
        if (v.wr) begin
          chk({nm, "_be"}, dmem_be_o, v.e_be);
          chk({nm, "_wdata"}, dmem_wdata_o, v.e_wdata);
        end
        chk({nm, "_rd_wait"}, rd_o, 32'd0);
        if (stall_o) stalls++;
        if (fault_o) fault_seen = 1'b1;
        waits++;
        @(negedge clk_i);
        dmem_ready_i = 1'b0;
      end else begin
        #1;
        chk({nm, "_rd"}, rd_o, v.e_rd);
        chk({nm, "_done_stall"}, stall_o, 1'b0);
        chk({nm, "_done_fault"}, fault_o, 1'b0);
        done = 1'b1;
      end
    end
    chk({nm, "_completed"}, done, 1'b1);
    chk({nm, "_stalls"}, stalls, v.e_stalls);
    chk({nm, "_fault"}, fault_seen, v.e_fault);
    @(negedge clk_i);
    #1;
    chk({nm, "_back_idle"}, dmem_req_o, 1'b0);
  endtask

  task automatic run_illegal(input logic rd, input logic wr, input logic [2:0] f3,
                             input logic [31:0] addr, input string nm);
    @(negedge clk_i);
    memreadm_i = rd; memwritem_i = wr; funct3m_i = f3; aluresultm_i = addr;
    #1;
    chk({nm, "_req"}, dmem_req_o, 1'b0);
    chk({nm, "_stall"}, stall_o, 1'b0);
    chk({nm, "_fault"}, fault_o, 1'b1);
    chk({nm, "_rd"}, rd_o, 32'd0);
    @(negedge clk_i);
    memreadm_i = 1'b0; memwritem_i = 1'b0;
    #1;
    chk({nm, "_req_after"}, dmem_req_o, 1'b0);
    chk({nm, "_fault_after"}, fault_o, 1'b0);
  endtask

  vec_t tbl[8];
  vec_t rv;

  initial begin
    tbl[0] = '{1'b0, 1'b1, 3'b010, 32'h104, 32'hDEADBEEF, 32'h0,        0, 32'h104, 4'hF, 32'hDEADBEEF, 32'h0,        2, 1'b0};
    tbl[1] = '{1'b0, 1'b1, 3'b000, 32'h103, 32'h000000A5, 32'h0,        0, 32'h100, 4'h8, 32'hA5A5A5A5, 32'h0,        2, 1'b0};
    tbl[2] = '{1'b1, 1'b0, 3'b001, 32'h202, 32'h0,        32'h80F07F01, 0, 32'h200, 4'h0, 32'h0,        32'hFFFF80F0, 2, 1'b0};
    tbl[3] = '{1'b1, 1'b0, 3'b101, 32'h202, 32'h0,        32'h80F07F01, 0, 32'h200, 4'h0, 32'h0,        32'h000080F0, 2, 1'b0};
    tbl[4] = '{1'b1, 1'b0, 3'b000, 32'h200, 32'h0,        32'h80F07F01, 0, 32'h200, 4'h0, 32'h0,        32'h00000001, 2, 1'b0};
    tbl[5] = '{1'b1, 1'b0, 3'b010, 32'h300, 32'h0,        32'h12345678, 5, 32'h300, 4'h0, 32'h0,        32'h12345678, 7, 1'b0};
    tbl[6] = '{1'b1, 1'b0, 3'b010, 32'h300, 32'h0,        32'h12345678, -1, 32'h300, 4'h0, 32'h0,       32'h0,        TO + 1, 1'b1};
    tbl[7] = '{1'b0, 1'b1, 3'b001, 32'h106, 32'h1234BEEF, 32'h0,        1, 32'h104, 4'hC, 32'hBEEFBEEF, 32'h0,        3, 1'b0};

    // Reset state
    reset_i = 1'b1;
    #2;
    chk("rst_req", dmem_req_o, 1'b0);
    chk("rst_we", dmem_we_o, 1'b0);
    chk("rst_addr", dmem_addr_o, 32'd0);
    chk("rst_be", dmem_be_o, 4'd0);
    chk("rst_wdata", dmem_wdata_o, 32'd0);
    chk("rst_rd", rd_o, 32'd0);
    chk("rst_stall", stall_o, 1'b0);
    chk("rst_fault", fault_o, 1'b0);
    @(negedge clk_i);
    reset_i = 1'b0;

    for (int i = 0; i < 8; i++) run_txn(tbl[i], $sformatf("vec%0d", i));

    run_illegal(1'b1, 1'b0, 3'b010, 32'h101, "ill_lw_mis");
    run_illegal(1'b1, 1'b0, 3'b011, 32'h100, "ill_f3_011");
    run_illegal(1'b1, 1'b1, 3'b010, 32'h100, "ill_both");
    run_illegal(1'b0, 1'b1, 3'b100, 32'h100, "ill_st_f3");
    run_illegal(1'b0, 1'b1, 3'b001, 32'h103, "ill_sh_mis");

    // Reset in the middle of WAIT
    @(negedge clk_i);
    memreadm_i = 1'b1; funct3m_i = 3'b010; aluresultm_i = 32'h400; dmem_ready_i = 1'b0;
    @(negedge clk_i);
    memreadm_i = 1'b0;
    #1;
    chk("midrst_req_before", dmem_req_o, 1'b1);
    #1;
    reset_i = 1'b1;
    #1;
    chk("midrst_req", dmem_req_o, 1'b0);
    chk("midrst_stall", stall_o, 1'b0);
    @(negedge clk_i);
    reset_i = 1'b0;
    run_txn(tbl[2], "after_rst");

    // Randomized legal accesses checked against the arithmetic model
    for (int n = 0; n < 40; n++) begin
      int unsigned k;
      rv.wr = 1'($urandom_range(0, 1));
      rv.rd = ~rv.wr;
      if (rv.wr) begin
        k = $urandom_range(0, 2);
        rv.f3 = 3'(k);
      end else begin
        k = $urandom_range(0, 4);
        rv.f3 = (k < 3) ? 3'(k) : 3'(k + 1);
      end
      rv.addr = $urandom;
      if (rv.f3[1:0] == 2'b01) rv.addr[0] = 1'b0;
      if (rv.f3[1:0] == 2'b10) rv.addr[1:0] = 2'b00;
      rv.wdata = $urandom;
      rv.rdata = $urandom;
      rv.delay = $urandom_range(0, 3);
      rv.e_addr = rv.addr & 32'hFFFFFFFC;
      model_store(rv.f3, rv.addr, rv.wdata, rv.e_be, rv.e_wdata);
      rv.e_rd = rv.wr ? 32'd0 : model_load(rv.f3, rv.addr, rv.rdata);
      rv.e_stalls = rv.delay + 2;
      rv.e_fault = 1'b0;
      run_txn(rv, $sformatf("rnd%0d", n));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
